// File: rtl/posit_seq_pkg.sv
// Shared types and defaults for the posit dot-product issue sequencer.
package posit_seq_pkg;

  localparam int unsigned VLD_STAGES_DEF = 12;
  localparam int unsigned DONE_TAP_DEF   = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Free-running shift register of issue tags; stage 0 holds the input delayed one cycle.
module tag_delay_line
  import posit_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  tag_t             i_tag,
  output tag_t [DEPTH-1:0] o_tags
);

  tag_t [DEPTH-1:0] r_tags;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_tags <= '0;
    end else if (i_clr) begin
      r_tags <= '0;
    end else begin
      r_tags <= {r_tags[DEPTH-2:0], i_tag};
    end
  end

  assign o_tags = r_tags;

endmodule

// File: rtl/posit_dot_seq.sv
// Dot-product job sequencer: issues operand reads, tags first/last products
// through a valid delay line and signals completion once the last one drains.
module posit_dot_seq
  import posit_seq_pkg::*;
#(
  parameter int unsigned LEN_W      = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned VLD_STAGES = VLD_STAGES_DEF,
  parameter int unsigned DONE_TAP   = DONE_TAP_DEF
) (
  input  logic                  clk_i,
  input  logic                  rstn,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  stall_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [LEN_W-1:0]      rd_addr_o,
  output logic [VLD_STAGES-1:0] vld_d_o,
  output logic [VLD_STAGES-1:0] first_d_o,
  output logic [VLD_STAGES-1:0] last_d_o
);

  // Pre-delay of RD_LAT stages followed by the VLD_STAGES taps seen by the datapath.
  localparam int unsigned DEPTH = RD_LAT + VLD_STAGES;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic             r_rd_en;
  logic             w_rd_en_nxt;
  logic [LEN_W-1:0] r_rd_addr;
  logic [LEN_W-1:0] w_rd_addr_nxt;
  logic             r_first;
  logic             w_first_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_busy;

  logic             w_active;
  logic             w_kill;
  logic             w_issue;
  logic             w_is_last;
  logic             w_tap_last;
  tag_t             w_tag_in;
  tag_t [DEPTH-1:0] w_tags;

  assign w_active   = (r_state != S_IDLE);
  assign w_kill     = abort_i && w_active;
  assign w_issue    = (r_state == S_ISSUE) && !stall_i && !abort_i;
  assign w_is_last  = (r_cnt == (r_len - LEN_W'(1)));
  assign w_tap_last = w_tags[RD_LAT-1+DONE_TAP].last;

  // State register
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort outranks both issue and completion
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_i && (len_i != '0)) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (abort_i)                   w_state_nxt = S_IDLE;
        else if (w_issue && w_is_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (abort_i)         w_state_nxt = S_IDLE;
        else if (w_tap_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values, registered below
  always_comb begin
    w_len_nxt     = r_len;
    w_cnt_nxt     = r_cnt;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_first_nxt   = 1'b0;
    w_last_nxt    = 1'b0;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            w_len_nxt = len_i;
            w_cnt_nxt = '0;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (w_issue) begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_cnt;
          w_first_nxt   = (r_cnt == '0);
          w_last_nxt    = w_is_last;
          w_cnt_nxt     = r_cnt + LEN_W'(1);
        end
      end
      S_DRAIN: begin
        w_done_nxt = w_tap_last && !abort_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_first   <= 1'b0;
      r_last    <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_len     <= w_len_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_first   <= w_first_nxt;
      r_last    <= w_last_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign w_tag_in = '{vld: r_rd_en, first: r_first, last: r_last};

  tag_delay_line #(
    .DEPTH (DEPTH)
  ) u_tag_delay_line (
    .i_clk  (clk_i),
    .i_rstn (rstn),
    .i_clr  (w_kill),
    .i_tag  (w_tag_in),
    .o_tags (w_tags)
  );

  for (genvar k = 0; k < VLD_STAGES; k++) begin : g_tap
    assign vld_d_o[k]   = w_tags[RD_LAT-1+k].vld;
    assign first_d_o[k] = w_tags[RD_LAT-1+k].first;
    assign last_d_o[k]  = w_tags[RD_LAT-1+k].last;
  end

  assign busy_o    = r_busy;
  assign done_o    = r_done;
  assign rd_en_o   = r_rd_en;
  assign rd_addr_o = r_rd_addr;

endmodule

// File: tb/tb_posit_dot_seq.sv
// Directed bench for posit_dot_seq: table of single jobs plus abort, reset and back-to-back sequences.
module tb_posit_dot_seq;

  logic        clk_i;
  logic        rstn;
  logic        start_i;
  logic [7:0]  len_i;
  logic        stall_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic        rd_en_o;
  logic [7:0]  rd_addr_o;
  logic [11:0] vld_d_o;
  logic [11:0] first_d_o;
  logic [11:0] last_d_o;

  posit_dot_seq #(
    .LEN_W      (8),
    .RD_LAT     (1),
    .VLD_STAGES (12),
    .DONE_TAP   (11)
  ) dut (
    .clk_i     (clk_i),
    .rstn      (rstn),
    .start_i   (start_i),
    .len_i     (len_i),
    .stall_i   (stall_i),
    .abort_i   (abort_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .rd_en_o   (rd_en_o),
    .rd_addr_o (rd_addr_o),
    .vld_d_o   (vld_d_o),
    .first_d_o (first_d_o),
    .last_d_o  (last_d_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Cycle c = interval after the c-th edge following the start request; stall bit c is driven during cycle c.
  typedef struct {
    int          len;
    logic [63:0] stall;
    logic [63:0] rd_mask;
    logic [63:0] v0_mask;
    int          first0;
    int          last0;
    int          last11;
    int          done;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int id);
    logic [63:0] rd_m, v0_m, busy_m;
    int f0, l0, l11, dn, ndone, rdi;
    rd_m = '0; v0_m = '0; busy_m = '0;
    f0 = -1; l0 = -1; l11 = -1; dn = -1; ndone = 0; rdi = 0;
    start_i = 1'b1;
    len_i   = 8'(v.len);
    stall_i = v.stall[0];
    for (int c = 1; c < 40; c++) begin
      tick();
      start_i = 1'b0;
      stall_i = v.stall[c];
      if (rd_en_o) begin
        rd_m[c] = 1'b1;
        chk($sformatf("v%0d addr@%0d", id, c), 64'(rd_addr_o), 64'(rdi));
        rdi++;
      end
      if (vld_d_o[0])                 v0_m[c] = 1'b1;
      if (busy_o)                     busy_m[c] = 1'b1;
      if (first_d_o[0] && f0 < 0)     f0 = c;
      if (last_d_o[0] && l0 < 0)      l0 = c;
      if (last_d_o[11] && l11 < 0)    l11 = c;
      if (done_o) begin
        ndone++;
        if (dn < 0) dn = c;
      end
    end
    stall_i = 1'b0;
    chk($sformatf("v%0d rd_mask", id), rd_m, v.rd_mask);
    chk($sformatf("v%0d vld0_mask", id), v0_m, v.v0_mask);
    chk($sformatf("v%0d first0", id), 64'(f0), 64'(v.first0));
    chk($sformatf("v%0d last0", id), 64'(l0), 64'(v.last0));
    chk($sformatf("v%0d last11", id), 64'(l11), 64'(v.last11));
    chk($sformatf("v%0d done_cyc", id), 64'(dn), 64'(v.done));
    chk($sformatf("v%0d done_cnt", id), 64'(ndone), 64'd1);
    chk($sformatf("v%0d busy_mask", id), busy_m, (64'd1 << v.done) - 64'd2);
  endtask

  logic [63:0] rd_m, dn_m, act_m;
  int          ndone;

  initial begin
    vecs[0] = '{4, 64'h0,   64'h3C, 64'h78, 3,  6, 17, 18};
    vecs[1] = '{3, 64'hC,   64'h64, 64'hC8, 3,  7, 18, 19};
    vecs[2] = '{0, 64'h0,   64'h0,  64'h0, -1, -1, -1,  1};
    vecs[3] = '{1, 64'h0,   64'h4,  64'h8,  3,  3, 14, 15};
    vecs[4] = '{2, 64'h0,   64'hC,  64'h18, 3,  4, 15, 16};
    vecs[5] = '{2, 64'h1F0, 64'hC,  64'h18, 3,  4, 15, 16};

    rstn = 1'b0; start_i = 1'b0; len_i = '0; stall_i = 1'b0; abort_i = 1'b0;
    #3;
    chk("reset outputs", 64'({busy_o, done_o, rd_en_o, rd_addr_o, vld_d_o, first_d_o, last_d_o}), 64'd0);
    #9 rstn = 1'b1;
    tick();
    tick();
    chk("idle after reset", 64'({busy_o, done_o, rd_en_o, vld_d_o}), 64'd0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort during DRAIN, then an immediate restart
    ndone = 0;
    start_i = 1'b1; len_i = 8'd4;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start_i = 1'b0;
      if (done_o) ndone++;
    end
    chk("abort pre vld_d", 64'(vld_d_o), 64'h0F0);
    chk("abort pre last_d", 64'(last_d_o), 64'h010);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort busy", 64'(busy_o), 64'd0);
    chk("abort lines", 64'({rd_en_o, vld_d_o, first_d_o, last_d_o}), 64'd0);
    if (done_o) ndone++;
    start_i = 1'b1; len_i = 8'd2;
    dn_m = '0;
    for (int c = 12; c < 40; c++) begin
      tick();
      start_i = 1'b0;
      if (done_o) begin
        ndone++;
        dn_m[c] = 1'b1;
      end
    end
    chk("abort done_cnt", 64'(ndone), 64'd1);
    chk("abort restart done", dn_m, 64'd1 << 27);

    // Back-to-back: ignored starts while busy, restart in the done cycle
    rd_m = '0; dn_m = '0;
    start_i = 1'b1; len_i = 8'd4;
    for (int c = 1; c < 45; c++) begin
      tick();
      start_i = 1'b0;
      if (c == 5 || c == 10) begin
        start_i = 1'b1;
        len_i   = 8'd7;
      end
      if (rd_en_o) rd_m[c] = 1'b1;
      if (done_o)  dn_m[c] = 1'b1;
      if (c == 21) chk("b2b addr@21", 64'(rd_addr_o), 64'd1);
      if (c == 18) begin
        chk("b2b done@18", 64'(done_o), 64'd1);
        start_i = 1'b1;
        len_i   = 8'd2;
      end
    end
    start_i = 1'b0;
    chk("b2b rd_mask", rd_m, 64'h3C | (64'd3 << 20));
    chk("b2b done_mask", dn_m, (64'd1 << 18) | (64'd1 << 34));

    // Asynchronous reset mid-ISSUE
    start_i = 1'b1; len_i = 8'd4;
    for (int c = 1; c <= 3; c++) begin
      tick();
      start_i = 1'b0;
    end
    chk("pre-reset rd", 64'({rd_en_o, rd_addr_o}), 64'h101);
    #2 rstn = 1'b0;
    #1;
    chk("async reset outputs", 64'({busy_o, done_o, rd_en_o, rd_addr_o, vld_d_o, first_d_o, last_d_o}), 64'd0);
    @(negedge clk_i);
    rstn = 1'b1;
    act_m = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      act_m[c] = busy_o | done_o | rd_en_o | (|vld_d_o);
    end
    chk("idle after async reset", act_m, 64'd0);
    run_vec(vecs[0], 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
